// File: rtl/axicb_pkg.sv
// Shared types and constants for the AXI crossbar switches.
// Route entries carry a misroute flag plus the target slave index.
package axicb_pkg;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Sized for the largest supported crossbar (16 slave ports).
    localparam int SLV_IDX_W = 4;

    typedef struct packed {
        logic                 mr;
        logic [SLV_IDX_W-1:0] idx;
    } route_t;

endpackage

// File: rtl/axicb_addr_decoder.sv
// Address map decoder: range compare per slave, lowest index wins overlaps.
// Returns a one-hot target, its index, and a misroute flag when nothing hits.
module axicb_addr_decoder
    import axicb_pkg::*;
#(
    parameter int                        ADDR_W     = 16,
    parameter int                        SLV_NB     = 8,
    parameter logic [SLV_NB-1:0]         MST_ROUTES = '1,
    parameter logic [SLV_NB*ADDR_W-1:0]  START_ADDR = '0,
    parameter logic [SLV_NB*ADDR_W-1:0]  END_ADDR   = '1
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic [SLV_NB-1:0]    tgt,
    output logic [SLV_IDX_W-1:0] idx,
    output logic                 misroute
);

    logic [SLV_NB-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            hit[i] = MST_ROUTES[i] &&
                     (addr >= START_ADDR[i*ADDR_W +: ADDR_W]) &&
                     (addr <= END_ADDR[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        tgt = '0;
        idx = '0;
        for (int i = SLV_NB - 1; i >= 0; i--) begin
            if (hit[i]) begin
                tgt    = '0;
                tgt[i] = 1'b1;
                idx    = SLV_IDX_W'(i);
            end
        end
    end

    assign misroute = ~|hit;

endmodule

// File: rtl/axicb_round_robin.sv
// Round-robin arbiter: lowest requester above the last served one wins,
// wrapping to the lowest requester overall.
module axicb_round_robin #(
    parameter int REQ_NB = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic [REQ_NB-1:0] req,
    input  logic              en,
    input  logic [REQ_NB-1:0] served,
    output logic [REQ_NB-1:0] grant
);

    localparam logic [REQ_NB-1:0] ONE = 1;

    logic [REQ_NB-1:0] mask_q, mask_d;
    logic [REQ_NB-1:0] masked;

    function automatic logic [REQ_NB-1:0] lowest(input logic [REQ_NB-1:0] v);
        return v & (~v + ONE);
    endfunction

    assign masked = req & mask_q;

    always_comb begin
        grant = (|masked) ? lowest(masked) : lowest(req);
    end

    // After a grant completes only requesters above it keep priority.
    always_comb begin
        mask_d = mask_q;
        if (en) begin
            mask_d = ~(served | (served - ONE));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mask_q <= '1;
        end else if (srst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/axicb_scfifo.sv
// Single-clock FIFO with power-of-two depth.
// Pointers carry one extra wrap bit to tell full from empty.
module axicb_scfifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH_W = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam logic [DEPTH_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH_W:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_W:0]  rd_ptr_q, rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                   (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
    assign data_out = mem_q[rd_ptr_q[DEPTH_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[DEPTH_W-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/axicb_slv_switch_wr_n.sv
// Master-side write switch: routes AW/W to N slaves, arbitrates B back,
// and answers unmapped writes with DECERR once their W burst has drained.
module axicb_slv_switch_wr_n
    import axicb_pkg::*;
#(
    parameter int AXI_ADDR_W = 16,
    parameter int AXI_ID_W = 8,
    parameter int SLV_NB = 8,
    parameter logic [SLV_NB-1:0] MST_ROUTES = {SLV_NB{1'b1}},
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR = {
        16'h7000, 16'h6000, 16'h5000, 16'h4000,
        16'h3000, 16'h2000, 16'h1000, 16'h0000},
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR = {
        16'h7FFF, 16'h6FFF, 16'h5FFF, 16'h4FFF,
        16'h3FFF, 16'h2FFF, 16'h1FFF, 16'h0FFF},
    parameter int AWCH_W = 32,
    parameter int WCH_W = 32,
    parameter int BCH_W = AXI_ID_W + 2,
    parameter int ROUTE_FIFO_DEPTH_W = 3,
    parameter int MR_FIFO_DEPTH_W = 2,
    parameter int MAX_OSTDG = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    input  logic                    i_awvalid,
    output logic                    i_awready,
    input  logic [AWCH_W-1:0]       i_awch,
    input  logic                    i_wvalid,
    output logic                    i_wready,
    input  logic                    i_wlast,
    input  logic [WCH_W-1:0]        i_wch,
    output logic                    i_bvalid,
    input  logic                    i_bready,
    output logic [BCH_W-1:0]        i_bch,
    output logic [SLV_NB-1:0]       o_awvalid,
    input  logic [SLV_NB-1:0]       o_awready,
    output logic [AWCH_W-1:0]       o_awch,
    output logic [SLV_NB-1:0]       o_wvalid,
    input  logic [SLV_NB-1:0]       o_wready,
    output logic [SLV_NB-1:0]       o_wlast,
    output logic [WCH_W-1:0]        o_wch,
    input  logic [SLV_NB-1:0]       o_bvalid,
    output logic [SLV_NB-1:0]       o_bready,
    input  logic [SLV_NB*BCH_W-1:0] o_bch
);

    localparam int OSTD_W = $clog2(MAX_OSTDG + 1);
    localparam int MRC_W  = MR_FIFO_DEPTH_W + 1;
    localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MAX_OSTDG);
    localparam logic [OSTD_W-1:0] OSTD_ONE = 1;
    localparam logic [MRC_W-1:0]  MRC_ONE  = 1;

    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [SLV_NB-1:0]     tgt;
    logic [SLV_IDX_W-1:0]  tgt_idx;
    logic                  misroute;

    logic   aw_ok, aw_hs;
    route_t route_in, route_head;
    logic   [$bits(route_t)-1:0] route_dout;
    logic   route_full, route_empty;

    logic [AXI_ID_W-1:0] mr_id;
    logic mr_full, mr_empty;

    logic [SLV_NB-1:0] w_sel;
    logic w_done, mr_drained;

    logic [OSTD_W-1:0] ostd_q, ostd_d;
    logic [MRC_W-1:0]  mr_done_q, mr_done_d;
    logic              lock_q, lock_d;
    logic [SLV_NB-1:0] grant_q, grant_d;

    logic [SLV_NB-1:0] rr_grant, grant;
    logic [BCH_W-1:0]  slv_bch;
    logic dec_pend, dec_act, slv_bvalid;
    logic b_hs, slv_b_hs, dec_hs;

    assign aw_addr = i_awch[0 +: AXI_ADDR_W];
    assign aw_id   = i_awch[AXI_ADDR_W +: AXI_ID_W];

    axicb_addr_decoder #(
        .ADDR_W     (AXI_ADDR_W),
        .SLV_NB     (SLV_NB),
        .MST_ROUTES (MST_ROUTES),
        .START_ADDR (SLV_START_ADDR),
        .END_ADDR   (SLV_END_ADDR)
    ) u_dec (
        .addr     (aw_addr),
        .tgt      (tgt),
        .idx      (tgt_idx),
        .misroute (misroute)
    );

    always_comb begin
        aw_ok     = ~route_full & (ostd_q < OSTD_MAX);
        o_awvalid = {SLV_NB{i_awvalid & aw_ok}} & tgt;
        i_awready = misroute ? (aw_ok & ~mr_full)
                             : (aw_ok & |(o_awready & tgt));
        aw_hs     = i_awvalid & i_awready;
        o_awch    = i_awch;
        route_in  = '{mr: misroute, idx: tgt_idx};
    end

    axicb_scfifo #(
        .DATA_W  ($bits(route_t)),
        .DEPTH_W (ROUTE_FIFO_DEPTH_W)
    ) u_route_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .push     (aw_hs),
        .data_in  (route_in),
        .pop      (w_done),
        .data_out (route_dout),
        .full     (route_full),
        .empty    (route_empty)
    );

    axicb_scfifo #(
        .DATA_W  (AXI_ID_W),
        .DEPTH_W (MR_FIFO_DEPTH_W)
    ) u_mr_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .push     (aw_hs & misroute),
        .data_in  (aw_id),
        .pop      (dec_hs),
        .data_out (mr_id),
        .full     (mr_full),
        .empty    (mr_empty)
    );

    assign route_head = route_t'(route_dout);

    // W follows the oldest accepted AW; misrouted bursts are swallowed.
    always_comb begin
        w_sel = '0;
        if (!route_empty && !route_head.mr) begin
            for (int i = 0; i < SLV_NB; i++) begin
                w_sel[i] = (route_head.idx == SLV_IDX_W'(i));
            end
        end
        o_wvalid   = {SLV_NB{i_wvalid}} & w_sel;
        o_wlast    = {SLV_NB{i_wlast}} & w_sel;
        o_wch      = i_wch;
        i_wready   = ~route_empty & (route_head.mr | |(o_wready & w_sel));
        w_done     = i_wvalid & i_wready & i_wlast;
        mr_drained = w_done & route_head.mr;
    end

    axicb_round_robin #(
        .REQ_NB (SLV_NB)
    ) u_rr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .req     (o_bvalid),
        .en      (slv_b_hs),
        .served  (grant),
        .grant   (rr_grant)
    );

    // A locked slave response finishes before any pending DECERR.
    always_comb begin
        dec_pend = (mr_done_q != '0) & ~mr_empty;
        dec_act  = ~lock_q & dec_pend;
        grant    = lock_q ? grant_q : (dec_pend ? '0 : rr_grant);
        slv_bch  = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            if (grant[i]) begin
                slv_bch = o_bch[i*BCH_W +: BCH_W];
            end
        end
        slv_bvalid = |(o_bvalid & grant);
        i_bvalid   = dec_act | slv_bvalid;
        i_bch      = dec_act ? {RESP_DECERR, mr_id} : slv_bch;
        o_bready   = {SLV_NB{i_bready & ~dec_act}} & grant;
        b_hs       = i_bvalid & i_bready;
        slv_b_hs   = b_hs & ~dec_act;
        dec_hs     = b_hs & dec_act;
    end

    always_comb begin
        lock_d  = lock_q;
        grant_d = grant_q;
        if (b_hs) begin
            lock_d = 1'b0;
        end else if (slv_bvalid) begin
            lock_d  = 1'b1;
            grant_d = grant;
        end

        ostd_d = ostd_q;
        if (aw_hs && !b_hs) begin
            ostd_d = ostd_q + OSTD_ONE;
        end else if (!aw_hs && b_hs && ostd_q != '0) begin
            ostd_d = ostd_q - OSTD_ONE;
        end

        mr_done_d = mr_done_q;
        if (mr_drained && !dec_hs) begin
            mr_done_d = mr_done_q + MRC_ONE;
        end else if (!mr_drained && dec_hs) begin
            mr_done_d = mr_done_q - MRC_ONE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ostd_q    <= '0;
            mr_done_q <= '0;
            lock_q    <= 1'b0;
            grant_q   <= '0;
        end else if (srst) begin
            ostd_q    <= '0;
            mr_done_q <= '0;
            lock_q    <= 1'b0;
            grant_q   <= '0;
        end else begin
            ostd_q    <= ostd_d;
            mr_done_q <= mr_done_d;
            lock_q    <= lock_d;
            grant_q   <= grant_d;
        end
    end

endmodule
